// File: rtl/esn7e_demo_system_nios2_qsys_oci_arbiter_if.sv
// Bundle of the CPU debug-slave, JTAG monitor and debug-RAM signals around the
// OCI arbiter. The arbiter uses the slave modport, its environment the master modport.
interface esn7e_demo_system_nios2_qsys_oci_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [37:0]       jdo;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;

  modport slave (
    input  take_action_ocimem_a, take_action_ocimem_b, jdo,
    input  avs_address, avs_read, avs_write, avs_writedata, ram_rdata,
    output avs_readdata, avs_waitrequest, ram_addr, ram_wren, ram_wdata,
    output MonDReg, MonAReg, monitor_ready, monitor_error
  );

  modport master (
    output take_action_ocimem_a, take_action_ocimem_b, jdo,
    output avs_address, avs_read, avs_write, avs_writedata, ram_rdata,
    input  avs_readdata, avs_waitrequest, ram_addr, ram_wren, ram_wdata,
    input  MonDReg, MonAReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/esn7e_demo_system_nios2_qsys_oci_arbiter.sv
// Round-robin arbiter sharing the OCI debug RAM between JTAG monitor and CPU debug slave.
// Optional ESN7E_OCI_ARB_AUTOINC_EN: MonAReg post-increments after each JTAG RAM access.
module esn7e_demo_system_nios2_qsys_oci_arbiter #(
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic reset_n,
  esn7e_demo_system_nios2_qsys_oci_arbiter_if.slave bus
);

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

`ifdef ESN7E_OCI_ARB_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]        state_q;

  logic              vld_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic              jtag_p1;
  logic              wr_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  logic              last_jtag_q;
  logic [ADDR_W-1:0] mon_a_q;
  logic [DATA_W-1:0] mon_d_q;
  logic [DATA_W-1:0] rd_hold_q;
  logic              ready_q;
  logic              err_q;

  logic              st_idle;
  logic              st_access;
  logic              st_done;
  logic              cpu_req;
  logic              grant_jtag;
  logic              grant_cpu;
  logic              retire_jtag;
  logic              retire_cpu_rd;
  logic              jtag_pulse;
  logic              pulse_accept;
  logic              pulse_drop;
  logic              load_a;
  logic              load_b;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] mon_a_base;
  logic              unused_jdo;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_access = (state_q == ST_ACCESS);
  assign st_done   = (state_q == ST_DONE);

  // Read+write together counts as a write; the strobe is only sampled in IDLE,
  // so a request withdrawn before that is simply never seen.
  assign cpu_req    = bus.avs_read | bus.avs_write;
  assign grant_jtag = st_idle & vld_p0 & (~cpu_req | ~last_jtag_q);
  assign grant_cpu  = st_idle & cpu_req & ~grant_jtag;

  assign retire_jtag   = st_done & jtag_p1;
  assign retire_cpu_rd = st_done & ~jtag_p1 & ~wr_p1;

  // The slot frees on the retiring edge, so a pulse landing then is accepted.
  // If both pulses arrive together, ocimem_a takes precedence.
  assign jtag_pulse   = bus.take_action_ocimem_a | bus.take_action_ocimem_b;
  assign pulse_accept = jtag_pulse & ~(vld_p0 & ~retire_jtag);
  assign pulse_drop   = jtag_pulse & ~pulse_accept;
  assign load_a       = pulse_accept & bus.take_action_ocimem_a;
  assign load_b       = pulse_accept & bus.take_action_ocimem_b & ~bus.take_action_ocimem_a;

  assign jdo_addr   = bus.jdo[ADDR_W+16:17];
  assign mon_a_base = (AUTOINC && retire_jtag) ? addr_wrap_inc(mon_a_q) : mon_a_q;
  assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};

  // ---- request stage: pending JTAG slot and arbitration state ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      vld_p0      <= 1'b0;
      wr_p0       <= 1'b0;
      jtag_p1     <= 1'b0;
      wr_p1       <= 1'b0;
      last_jtag_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:   state_q <= (grant_jtag | grant_cpu) ? ST_ACCESS : ST_IDLE;
        ST_ACCESS: state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase

      if (load_a) begin
        vld_p0 <= bus.jdo[34];
        wr_p0  <= 1'b0;
      end else if (load_b) begin
        vld_p0 <= 1'b1;
        wr_p0  <= 1'b1;
      end else if (retire_jtag) begin
        vld_p0 <= 1'b0;
      end

      if (grant_jtag | grant_cpu) begin
        jtag_p1     <= grant_jtag;
        wr_p1       <= grant_jtag ? wr_p0 : bus.avs_write;
        last_jtag_q <= grant_jtag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_a) begin
      addr_p0 <= jdo_addr;
    end else if (load_b) begin
      addr_p0 <= mon_a_base;
      data_p0 <= bus.jdo[34:3];
    end

    if (grant_jtag | grant_cpu) begin
      addr_p1 <= grant_jtag ? addr_p0 : bus.avs_address;
      data_p1 <= grant_jtag ? data_p0 : bus.avs_writedata;
    end
  end

  // ---- grant stage: RAM access in ACCESS, result capture leaving DONE ----
  assign bus.ram_addr  = st_access ? addr_p1 : '0;
  assign bus.ram_wren  = st_access & wr_p1;
  assign bus.ram_wdata = data_p1;

  // RAM data arrives in DONE, so the CPU sees it directly while waitrequest is low
  // and the held copy afterwards.
  assign bus.avs_waitrequest = ~(st_done & ~jtag_p1);
  assign bus.avs_readdata    = retire_cpu_rd ? bus.ram_rdata : rd_hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      rd_hold_q <= '0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      mon_a_q <= load_a ? jdo_addr : mon_a_base;

      if (retire_jtag && !wr_p1) begin
        mon_d_q <= bus.ram_rdata;
      end
      if (retire_cpu_rd) begin
        rd_hold_q <= bus.ram_rdata;
      end

      if (load_b || (load_a && bus.jdo[34])) begin
        ready_q <= 1'b0;
      end else if (retire_jtag) begin
        ready_q <= 1'b1;
      end

      if (pulse_drop) begin
        err_q <= 1'b1;
      end else if (load_a && bus.jdo[35]) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.MonAReg       = mon_a_q;
  assign bus.MonDReg       = mon_d_q;
  assign bus.monitor_ready = ready_q;
  assign bus.monitor_error = err_q;

endmodule

// File: tb/tb_esn7e_demo_system_nios2_qsys_oci_arbiter.sv
// Bench for the OCI arbiter: directed scenarios then random JTAG/CPU traffic,
// each cycle compared against a timeline model of the shared debug RAM.
module tb_esn7e_demo_system_nios2_qsys_oci_arbiter;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset_n;

  esn7e_demo_system_nios2_qsys_oci_arbiter_if #(.ADDR_W(AW)) bus();

  esn7e_demo_system_nios2_qsys_oci_arbiter #(.ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous single-port RAM, one-cycle read latency.
  logic [31:0] ram [256];
  bit   [255:0] ram_wr;
  always @(posedge clk) begin
    if (bus.ram_wren) begin
      ram[bus.ram_addr]    <= bus.ram_wdata;
      ram_wr[bus.ram_addr] <= 1'b1;
    end
    bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram[bus.ram_addr] : init_val(bus.ram_addr);
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a service occupies the RAM in cycle s_start and completes in
  // s_start+1; the arbiter looks for new work again from s_start+2.
  logic [31:0] ref_mem [256];
  int          cyc;
  bit          s_vld, s_cpu, s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_data;
  int          s_start;
  bit          p_vld, p_wr;
  logic [7:0]  p_addr;
  logic [31:0] p_data;
  bit          jtag_last;
  logic [7:0]  m_mona;
  logic [31:0] m_mond;
  bit          m_ready, m_err;

  task automatic model_reset();
    s_vld = 0; p_vld = 0; jtag_last = 0;
    m_mona = '0; m_mond = '0; m_ready = 1; m_err = 0;
  endtask

  task automatic model_update();
    bit free, cpu_req, pulse;
    free = !s_vld;
    if (s_vld && cyc == s_start && s_wr) ref_mem[s_addr] = s_data;
    if (s_vld && cyc == s_start + 1) begin
      if (!s_cpu) begin
        if (!s_wr) m_mond = ref_mem[s_addr];
        m_ready = 1;
        p_vld   = 0;
`ifdef ESN7E_OCI_ARB_AUTOINC_EN
        m_mona  = m_mona + 8'd1;
`endif
      end
      s_vld = 0;
    end
    cpu_req = bus.avs_read | bus.avs_write;
    if (free) begin
      if (p_vld && (!cpu_req || !jtag_last)) begin
        s_vld = 1; s_cpu = 0; s_wr = p_wr; s_addr = p_addr; s_data = p_data;
        s_start = cyc + 1; jtag_last = 1;
      end else if (cpu_req) begin
        s_vld = 1; s_cpu = 1; s_wr = bus.avs_write; s_addr = bus.avs_address;
        s_data = bus.avs_writedata; s_start = cyc + 1; jtag_last = 0;
      end
    end
    pulse = bus.take_action_ocimem_a | bus.take_action_ocimem_b;
    if (pulse && p_vld) begin
      m_err = 1;
    end else if (bus.take_action_ocimem_a) begin
      m_mona = bus.jdo[24:17];
      if (bus.jdo[35]) m_err = 0;
      if (bus.jdo[34]) begin
        p_vld = 1; p_wr = 0; p_addr = bus.jdo[24:17]; m_ready = 0;
      end
    end else if (bus.take_action_ocimem_b) begin
      p_vld = 1; p_wr = 1; p_addr = m_mona; p_data = bus.jdo[34:3]; m_ready = 0;
    end
    cyc++;
  endtask

  task automatic check_cycle();
    bit in_acc, in_done;
    in_acc  = s_vld && (cyc == s_start);
    in_done = s_vld && (cyc == s_start + 1);
    chk("waitrequest", bus.avs_waitrequest, !(in_done && s_cpu));
    chk("ram_wren", bus.ram_wren, in_acc && s_wr);
    chk("ram_addr", bus.ram_addr, in_acc ? s_addr : 8'h00);
    if (in_acc && s_wr) chk("ram_wdata", bus.ram_wdata, s_data);
    if (in_done && s_cpu && !s_wr) chk("avs_readdata", bus.avs_readdata, ref_mem[s_addr]);
    chk("MonAReg", bus.MonAReg, m_mona);
    chk("MonDReg", bus.MonDReg, m_mond);
    chk("monitor_ready", bus.monitor_ready, m_ready);
    chk("monitor_error", bus.monitor_error, m_err);
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    check_cycle();
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input bit rd, input bit clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = addr;
    j[34]    = rd;
    j[35]    = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic pulse_a(input logic [7:0] addr, input bit rd, input bit clr);
    bus.jdo = mk_a(addr, rd, clr);
    bus.take_action_ocimem_a = 1'b1;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    bus.jdo = mk_b(data);
    bus.take_action_ocimem_b = 1'b1;
  endtask

  initial begin
    int lat, cnt, waddr;
    logic [7:0] exp_a;
    bit cpu_act;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);
    reset_n = 1'b0;
    bus.take_action_ocimem_a = 0; bus.take_action_ocimem_b = 0; bus.jdo = '0;
    bus.avs_address = '0; bus.avs_read = 0; bus.avs_write = 0; bus.avs_writedata = '0;
    model_reset();
    cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", bus.avs_waitrequest, 1);
    chk("rst_readdata", bus.avs_readdata, 0);
    chk("rst_wren", bus.ram_wren, 0);
    chk("rst_ready", bus.monitor_ready, 1);
    reset_n = 1'b1;
    check_cycle();

    // JTAG address load + read of 0x10
    pulse_a(8'h10, 1, 0);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (!bus.monitor_ready) cnt++;
      else if (cnt > 0) break;
    end
    chk("jtag_rd_mond", bus.MonDReg, 32'hDEADBEEF);
    chk("jtag_rd_ready_low_cycles", cnt, 3);
    chk("jtag_rd_mona", bus.MonAReg, 8'h10);

    // CPU write 0x12345678 to 0x20
    bus.avs_write = 1; bus.avs_address = 8'h20; bus.avs_writedata = 32'h12345678;
    lat = -1; cnt = 0; waddr = -1;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (bus.ram_wren) begin cnt++; waddr = bus.ram_addr; end
      if (!bus.avs_waitrequest) begin lat = n; break; end
    end
    bus.avs_write = 0;
    chk("cpu_wr_latency", lat, 2);
    chk("cpu_wr_wren_cycles", cnt, 1);
    chk("cpu_wr_addr", waddr, 32'h20);
    step();

    // tie with last grant CPU: JTAG first, CPU 3 cycles later than usual
    pulse_a(8'h11, 1, 0);
    step();
    bus.avs_read = 1; bus.avs_address = 8'h20;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (!bus.avs_waitrequest) begin lat = n; break; end
    end
    chk("tie1_cpu_latency", lat, 5);
    chk("tie1_cpu_rdata", bus.avs_readdata, 32'h12345678);
    chk("tie1_jtag_done", bus.monitor_ready, 1);
    bus.avs_read = 0;
    step();

    // JTAG-only access, then a tie: CPU first
    pulse_a(8'h12, 1, 0);
    for (int n = 0; n < 8; n++) begin
      step();
      if (bus.monitor_ready) break;
    end
    pulse_a(8'h13, 1, 0);
    step();
    bus.avs_read = 1; bus.avs_address = 8'h21;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (!bus.avs_waitrequest) begin lat = n; break; end
    end
    bus.avs_read = 0;
    chk("tie2_cpu_latency", lat, 2);
    chk("tie2_jtag_pending", bus.monitor_ready, 0);
    for (int n = 0; n < 8; n++) begin
      step();
      if (bus.monitor_ready) break;
    end
    chk("tie2_jtag_mond", bus.MonDReg, init_val(8'h13));

    // back-to-back ocimem_b: second dropped
    cnt = 0;
    pulse_b(32'hA1A1A1A1);
    step();
    if (bus.ram_wren) cnt++;
    pulse_b(32'hB2B2B2B2);
    for (int n = 0; n < 7; n++) begin
      step();
      if (bus.ram_wren) cnt++;
    end
    chk("overrun_writes", cnt, 1);
    chk("overrun_error", bus.monitor_error, 1);
    pulse_a(8'h00, 0, 1);
    step();
    chk("error_clear", bus.monitor_error, 0);

    // address 0xFF write with optional wrap
    pulse_a(8'hFF, 0, 0);
    step();
    pulse_b(32'hCAFEF00D);
    waddr = -1;
    for (int n = 0; n < 7; n++) begin
      step();
      if (bus.ram_wren) waddr = bus.ram_addr;
    end
`ifdef ESN7E_OCI_ARB_AUTOINC_EN
    exp_a = 8'h00;
`else
    exp_a = 8'hFF;
`endif
    chk("wrap_waddr", waddr, 32'hFF);
    chk("wrap_mona", bus.MonAReg, exp_a);

    // pulse accepted in the retiring cycle
    pulse_a(8'h05, 1, 0);
    step(); step(); step();
    pulse_b(32'h0BADF00D);
    step();
    chk("retire_accept_err", bus.monitor_error, 0);
    chk("retire_accept_ready", bus.monitor_ready, 0);
    for (int n = 0; n < 8; n++) begin
      step();
      if (bus.monitor_ready) break;
    end
    chk("retire_accept_done", bus.monitor_ready, 1);

    // reset during ACCESS of a CPU write
    bus.avs_write = 1; bus.avs_address = 8'h40; bus.avs_writedata = 32'h55AA55AA;
    step();
    chk("abort_in_access", bus.ram_wren, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_waitrequest", bus.avs_waitrequest, 1);
    chk("abort_wren", bus.ram_wren, 0);
    chk("abort_addr", bus.ram_addr, 0);
    chk("abort_readdata", bus.avs_readdata, 0);
    chk("abort_mond", bus.MonDReg, 0);
    chk("abort_mona", bus.MonAReg, 0);
    chk("abort_ready", bus.monitor_ready, 1);
    chk("abort_error", bus.monitor_error, 0);
    bus.avs_write = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_write", ram_wr[8'h40], 0);
    reset_n = 1'b1;
    check_cycle();

    // random traffic
    cpu_act = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cpu_act) begin
        if (!bus.avs_waitrequest) begin
          cpu_act = 0; bus.avs_read = 0; bus.avs_write = 0;
        end else if (!(s_vld && s_cpu) && $urandom_range(0, 15) == 0) begin
          cpu_act = 0; bus.avs_read = 0; bus.avs_write = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        int k;
        cpu_act = 1;
        k = $urandom_range(0, 7);
        bus.avs_read  = (k != 0 && k < 5) || k == 7;
        bus.avs_write = (k == 0) || (k >= 5);
        bus.avs_address = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        bus.avs_writedata = $urandom;
      end
      if ($urandom_range(0, p_vld ? 19 : 3) == 0) begin
        int k;
        logic [7:0] a;
        k = $urandom_range(0, 7);
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        if (k < 3)      pulse_a(a, 1, 0);
        else if (k < 6) pulse_b($urandom);
        else if (k == 6) pulse_a(a, 0, 0);
        else            pulse_a(a, $urandom_range(0, 1) == 1, 1);
      end
      step();
    end
    for (int n = 0; n < 20; n++) begin
      if (cpu_act && !bus.avs_waitrequest) begin
        cpu_act = 0; bus.avs_read = 0; bus.avs_write = 0;
      end
      step();
    end
    chk("drain_jtag_idle", bus.monitor_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
